q_nibble_packer: RTL and testbench

- Sits downstream of the 4-bit up/down counter/latch block and consumes its Q bus.
- Samples Q nibbles on a qualifying strobe and packs each consecutive pair into a byte.
- Buffers bytes in a small synchronous FIFO and presents them on a valid/ready byte interface for a logger or serial stage.
- Flags when the buffer overflows.

---
 rtl/tutor_pkg.sv | 22 ++
 rtl/q_nibble_packer_if.sv | 29 ++
 rtl/q_sync_fifo.sv | 66 ++++++
 rtl/q_nibble_packer.sv | 103 ++++++++++
 tb/tb_q_nibble_packer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/tutor_pkg.sv
// Shared widths, pair-state encoding and a constant clog2 for the nibble packer slice.
package tutor_pkg;

    localparam int unsigned NIB_W  = 4;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } pair_state_e;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/q_nibble_packer_if.sv
// Nibble input, byte output and status signals of the nibble packer.
interface q_nibble_packer_if
    import tutor_pkg::*;
#(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned LVL_W = clog2(DEPTH) + 1;

    logic [NIB_W-1:0]  q_in;
    logic              q_valid;
    logic              flush;
    logic [BYTE_W-1:0] byte_out;
    logic              byte_valid;
    logic              byte_ready;
    logic [LVL_W-1:0]  level;
    logic              full;
    logic              ovf;

    modport master (
        output q_in, q_valid, flush, byte_ready,
        input  byte_out, byte_valid, level, full, ovf
    );

    modport slave (
        input  q_in, q_valid, flush, byte_ready,
        output byte_out, byte_valid, level, full, ovf
    );

endinterface

// File: rtl/q_sync_fifo.sv
// First-word-fall-through synchronous FIFO with level/full/empty, synchronous active-high clear.
module q_sync_fifo
    import tutor_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    push,
    input  logic [WIDTH-1:0]        wdata,
    input  logic                    pop,
    output logic [WIDTH-1:0]        rdata,
    output logic [clog2(DEPTH):0]   level,
    output logic                    full,
    output logic                    empty
);
    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_d;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only taken when a pop frees the head slot in the same cycle.
    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        level_d = level;
        if (do_push && !do_pop) begin
            level_d = level + LW'(1);
        end else if (do_pop && !do_push) begin
            level_d = level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_d;
            full  <= (level_d == LW'(DEPTH));
            empty <= (level_d == '0);
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/q_nibble_packer.sv
// Packs accepted Q nibbles pairwise into bytes, buffers them in a FIFO and flags overflow.
module q_nibble_packer
    import tutor_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter bit          CHANGE_ONLY = 1'b0,
    parameter bit          HI_FIRST    = 1'b1
) (
    input  logic              clk,
    input  logic              clr,
    q_nibble_packer_if.slave  bus
);
    pair_state_e       state_q;
    pair_state_e       state_d;
    logic [NIB_W-1:0]  stored_q;
    logic [NIB_W-1:0]  stored_d;
    logic [NIB_W-1:0]  last_q;
    logic              have_last_q;
    logic              ovf_q;
    logic              accept_c;
    logic              push_c;
    logic              pop_c;
    logic [BYTE_W-1:0] pack_c;
    logic              fifo_full;
    logic              fifo_empty;

    // Until the first accept there is no last nibble, so that accept is never suppressed.
    always_comb begin
        accept_c = 1'b0;
        if (bus.q_valid) begin
            accept_c = !CHANGE_ONLY || !have_last_q || (bus.q_in != last_q);
        end
        pop_c = ~fifo_empty & bus.byte_ready;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Pair state machine; flush discards a half-formed byte and wins over a coincident accept.
    always_comb begin
        state_d  = state_q;
        stored_d = stored_q;
        push_c   = 1'b0;
        pack_c   = HI_FIRST ? {stored_q, bus.q_in} : {bus.q_in, stored_q};
        if (bus.flush) begin
            state_d = ST_EMPTY;
        end else if (accept_c) begin
            case (state_q)
                ST_EMPTY: begin
                    stored_d = bus.q_in;
                    state_d  = ST_HALF;
                end
                ST_HALF: begin
                    push_c  = 1'b1;
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            stored_q    <= '0;
            last_q      <= '0;
            have_last_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            stored_q <= stored_d;
            if (accept_c) begin
                last_q      <= bus.q_in;
                have_last_q <= 1'b1;
            end
            if (push_c && fifo_full && !pop_c) begin
                ovf_q <= 1'b1;
            end
        end
    end

    q_sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (push_c),
        .wdata (pack_c),
        .pop   (pop_c),
        .rdata (bus.byte_out),
        .level (bus.level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.byte_valid = ~fifo_empty;
    assign bus.full       = fifo_full;
    assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_q_nibble_packer.sv
// Scoreboard bench: three packer configurations share one stimulus stream, each checked against a queue model.
module tb_q_nibble_packer;

    localparam int unsigned DEPTH = 4;
    localparam int          NI    = 3;

    logic       clk = 1'b0;
    logic       clr;
    logic [3:0] q_in;
    logic       q_valid;
    logic       flush;
    logic       byte_ready;

    always #5 clk = ~clk;

    logic [7:0] bo [NI];
    logic       bv [NI];
    logic [2:0] lv [NI];
    logic       fu [NI];
    logic       ov [NI];

    // Instance 0: defaults, 1: low nibble first, 2: change-only.
    for (genvar g = 0; g < NI; g++) begin : g_dut
        q_nibble_packer_if #(.DEPTH(DEPTH)) bus ();
        assign bus.q_in       = q_in;
        assign bus.q_valid    = q_valid;
        assign bus.flush      = flush;
        assign bus.byte_ready = byte_ready;
        assign bo[g] = bus.byte_out;
        assign bv[g] = bus.byte_valid;
        assign lv[g] = bus.level;
        assign fu[g] = bus.full;
        assign ov[g] = bus.ovf;
        q_nibble_packer #(
            .DEPTH       (DEPTH),
            .CHANGE_ONLY (g == 2),
            .HI_FIRST    (g != 1)
        ) dut (
            .clk (clk),
            .clr (clr),
            .bus (bus)
        );
    end

    int         checks   = 0;
    int         failures = 0;
    int         lvl      [NI];
    bit         movf     [NI];
    bit         has_last [NI];
    logic [3:0] last     [NI];
    bit         has_pend [NI];
    logic [3:0] pend     [NI];
    logic [7:0] expq     [NI][$];
    bit         prev_clr;

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d actual=%0h required=%0h", name, k, act, exp);
        end
    endtask

    task automatic report_fail(input string name, input int k);
        checks++;
        failures++;
        $display("FAIL %s inst=%0d actual=pop required=no_pop", name, k);
    endtask

    // Reference behaviour for the edge that follows the inputs just driven.
    task automatic model_edge(input int k, input bit c, input bit v, input logic [3:0] q, input bit f, input bit r);
        bit         popn;
        bit         pushn;
        bit         acc;
        logic [7:0] b;
        if (c) begin
            lvl[k]      = 0;
            movf[k]     = 1'b0;
            has_last[k] = 1'b0;
            has_pend[k] = 1'b0;
            expq[k].delete();
            return;
        end
        popn  = r && (lvl[k] > 0);
        pushn = 1'b0;
        acc   = v && ((k != 2) || !has_last[k] || (q != last[k]));
        if (acc && !f) begin
            if (!has_pend[k]) begin
                pend[k]     = q;
                has_pend[k] = 1'b1;
            end else begin
                b = (k != 1) ? {pend[k], q} : {q, pend[k]};
                has_pend[k] = 1'b0;
                if (lvl[k] < int'(DEPTH) || popn) begin
                    expq[k].push_back(b);
                    pushn = 1'b1;
                end else begin
                    movf[k] = 1'b1;
                end
            end
        end
        if (acc) begin
            last[k]     = q;
            has_last[k] = 1'b1;
        end
        if (f) has_pend[k] = 1'b0;
        lvl[k] = lvl[k] + int'(pushn) - int'(popn);
    endtask

    // One clock: check status left by the previous edge, then drive inputs for the next edge.
    task automatic step(input bit c, input bit v, input logic [3:0] q, input bit f, input bit r);
        logic [5:0] act;
        logic [5:0] exp;
        @(posedge clk);
        #2;
        for (int k = 0; k < NI; k++) begin
            act = {bv[k], lv[k], fu[k], ov[k]};
            exp = {lvl[k] > 0, 3'(lvl[k]), lvl[k] == int'(DEPTH), movf[k]};
            check("status", k, 32'(act), 32'(exp));
            if (prev_clr) check("reset_byte_out", k, 32'(bo[k]), 32'h0);
        end
        clr        = c;
        q_valid    = v;
        q_in       = q;
        flush      = f;
        byte_ready = r;
        prev_clr   = c;
        for (int k = 0; k < NI; k++) model_edge(k, c, v, q, f, r);
    endtask

    task automatic strobe_seq(input logic [3:0] n0, input int cnt, input bit r);
        for (int i = 0; i < cnt; i++) step(1'b0, 1'b1, 4'(n0 + 4'(i)), 1'b0, r);
    endtask

    task automatic drain(input int cnt);
        for (int i = 0; i < cnt; i++) step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    endtask

    // Monitor: every accepted head byte is compared with the oldest expected byte.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (clr === 1'b0 && byte_ready === 1'b1) begin
                for (int k = 0; k < NI; k++) begin
                    if (bv[k] === 1'b1) begin
                        if (expq[k].size() == 0) begin
                            report_fail("unexpected_byte", k);
                        end else begin
                            e = expq[k].pop_front();
                            check("byte", k, 32'(bo[k]), 32'(e));
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [3:0] rq;
        clr = 1'b1; q_valid = 1'b0; q_in = 4'h0; flush = 1'b0; byte_ready = 1'b0;
        prev_clr = 1'b1;
        for (int k = 0; k < NI; k++) model_edge(k, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);

        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'h6, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'h7, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        check("pair_hi_first", 0, 32'(bo[0]), 32'h67);
        check("pair_lo_first", 1, 32'(bo[1]), 32'h76);
        check("pair_level", 0, 32'(lv[0]), 32'd1);
        drain(3);

        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        begin
            logic [3:0] seq [8];
            seq = '{4'h3, 4'h3, 4'h3, 4'h9, 4'h9, 4'hA, 4'hA, 4'h5};
            for (int i = 0; i < 8; i++) step(1'b0, 1'b1, seq[i], 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        check("change_only_level", 2, 32'(lv[2]), 32'd2);
        check("change_only_head", 2, 32'(bo[2]), 32'h39);
        drain(6);

        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        strobe_seq(4'h0, 10, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        check("overflow_flag", 0, 32'(ov[0]), 32'd1);
        check("overflow_full", 0, 32'(fu[0]), 32'd1);
        check("overflow_head", 0, 32'(bo[0]), 32'h01);
        drain(6);

        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        strobe_seq(4'h0, 9, 1'b0);
        step(1'b0, 1'b1, 4'h9, 1'b0, 1'b1);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        check("full_pushpop_level", 0, 32'(lv[0]), 32'd4);
        check("full_pushpop_ovf", 0, 32'(ov[0]), 32'd0);
        drain(6);

        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'hC, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 4'h1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'h2, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        check("flush_pair", 0, 32'(bo[0]), 32'h12);
        check("flush_level", 0, 32'(lv[0]), 32'd1);
        drain(3);
        step(1'b0, 1'b1, 4'hC, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'h1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'h2, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        check("clr_pair", 0, 32'(bo[0]), 32'h12);
        drain(3);

        for (int i = 0; i < 1500; i++) begin
            rq = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 1) == 1,
                 rq,
                 $urandom_range(0, 19) == 0,
                 (i < 750) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0));
        end

        drain(8);
        @(negedge clk);
        #1;
        for (int k = 0; k < NI; k++) check("leftover", k, 32'(expq[k].size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
